// File: rtl/data_mover_wr.sv
`default_nettype none
// ============================================================================
// Module      : data_mover_wr
// Description : Byte-stream to BRAM writer. Packs PACK input bytes
//               little-endian into one DWIDTH word and writes a run of
//               words starting at a latched base address (wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mover_wr #(
  parameter int D_BW   = 8,
  parameter int AWIDTH = 6,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [AWIDTH-1:0] i_base_addr,
  input  logic [AWIDTH:0]   i_num_words,
  input  logic              i_valid,
  input  logic [D_BW-1:0]   i_data,
  output logic              o_ready,
  output logic              o_ce,
  output logic              o_we,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_wdata,
  output logic              o_idle,
  output logic              o_running,
  output logic              o_done
);

  localparam int PACK = DWIDTH / D_BW;
  localparam int BCW  = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BCW-1:0]    byte_cnt;
  logic [AWIDTH:0]   word_cnt;
  logic [AWIDTH:0]   num_words;
  logic [AWIDTH-1:0] base_addr;
  logic [DWIDTH-1:0] pack;
  logic [DWIDTH-1:0] word_nxt;
  logic              start;
  logic              accept;
  logic              last_byte;
  logic              final_byte;

  assign start      = (state == S_IDLE) && i_run;
  assign o_ready    = (state == S_RUN);
  assign accept     = i_valid && o_ready;
  assign last_byte  = accept && (byte_cnt == BCW'(PACK - 1));
  // The word counter is one bit wider than the address so a full 2^AWIDTH run can end.
  assign final_byte = last_byte && ((word_cnt + 1'b1) == num_words);

  assign o_idle    = (state == S_IDLE);
  assign o_running = (state == S_RUN) || (state == S_DRAIN);
  assign o_done    = (state == S_DONE);

  // Insert the incoming byte into its little-endian slot of the pack register.
  always_comb begin
    word_nxt = pack;
    for (int k = 0; k < PACK; k++) begin
      if (byte_cnt == BCW'(k)) begin
        word_nxt[k*D_BW +: D_BW] = i_data;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length request completes without entering RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_run) state_nxt = (i_num_words == '0) ? S_DONE : S_RUN;
      S_RUN:   if (final_byte) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the request, pack bytes, and register one write per full word.
  // Reset clears the registered write strobe, so a pending write never escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr <= '0;
      num_words <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      pack      <= '0;
      o_ce      <= 1'b0;
      o_we      <= 1'b0;
      o_addr    <= '0;
      o_wdata   <= '0;
    end else begin
      o_ce <= 1'b0;
      o_we <= 1'b0;
      if (start) begin
        base_addr <= i_base_addr;
        num_words <= i_num_words;
        byte_cnt  <= '0;
        word_cnt  <= '0;
        pack      <= '0;
      end else if (accept) begin
        pack <= word_nxt;
        if (last_byte) begin
          byte_cnt <= '0;
          word_cnt <= word_cnt + 1'b1;
          o_ce     <= 1'b1;
          o_we     <= 1'b1;
          o_addr   <= base_addr + word_cnt[AWIDTH-1:0];
          o_wdata  <= word_nxt;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mover_wr.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mover_wr
// Description : Scoreboard bench for data_mover_wr. Expected writes and
//               completion pulses are queued from a transfer-level model;
//               a monitor pops and compares whenever the DUT writes or
//               signals done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mover_wr;

  localparam int AW = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_run;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_num_words;
  logic          i_valid;
  logic [7:0]    i_data;
  logic          o_ready, o_ce, o_we, o_idle, o_running, o_done;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_wdata;

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  int   done_q[$];
  logic [7:0] tx_q[$];

  data_mover_wr #(.D_BW(8), .AWIDTH(AW), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_base_addr(i_base_addr),
    .i_num_words(i_num_words), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_ce(o_ce), .o_we(o_we), .o_addr(o_addr),
    .o_wdata(o_wdata), .o_idle(o_idle), .o_running(o_running), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_ce || o_we) check(o_ce == o_we, "ce_we_pair", {o_ce, o_we}, 2'b11);
      if (o_we) begin
        check(exp_q.size() > 0, "write_expected", 64'(exp_q.size()), 1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check(o_addr == e.addr, "write_addr", o_addr, e.addr);
          check(o_wdata == e.data, "write_data", o_wdata, e.data);
        end
      end
      if (o_done) begin
        check(done_q.size() > 0, "done_expected", 64'(done_q.size()), 1);
        if (done_q.size() > 0) void'(done_q.pop_front());
      end
    end
  end

  // Reference model: word w is bytes 4w..4w+3, lowest byte first, at (base+w) mod 64.
  task automatic model(input int base, input int num, input int n_sent);
    for (int w = 0; w < num && (4*w + 3) < n_sent; w++) begin
      wr_t e;
      logic [31:0] d;
      d = 0;
      for (int k = 0; k < 4; k++) d = d | (32'(tx_q[4*w + k]) << (8*k));
      e.addr = AW'((base + w) % 64);
      e.data = d;
      exp_q.push_back(e);
    end
    if (n_sent == 4*num) done_q.push_back(1);
  endtask

  task automatic fill_random(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic fill_seq(input logic [7:0] first, input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(first + 8'(i));
  endtask

  // Run one transfer, sending the first n_send bytes of tx_q. A full transfer
  // also checks the DRAIN/DONE/IDLE timing after the final byte.
  task automatic xfer(input int base, input int num, input int n_send, input bit bubble, input bit run_mid);
    int  idx;
    int  cyc;
    bit  v;
    bit  acc;
    model(base, num, n_send);
    i_run = 1'b1; i_base_addr = AW'(base); i_num_words = (AW+1)'(num);
    tick();
    i_run = 1'b0; i_base_addr = AW'($urandom); i_num_words = '0;
    check(o_running == 1'b1, "running_after_start", o_running, 1);
    idx = 0; cyc = 0;
    while (idx < n_send && cyc < 4000) begin
      check(o_ready == 1'b1, "ready_in_run", o_ready, 1);
      v = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
      i_valid = v;
      i_data  = v ? tx_q[idx] : 8'($urandom);
      if (run_mid && idx == 2) begin
        i_run = 1'b1; i_num_words = '0; i_base_addr = AW'($urandom);
      end
      acc = v && o_ready;
      tick();
      i_run = 1'b0;
      cyc++;
      if (acc) idx++;
    end
    check(cyc < 4000, "send_timeout", cyc, 4000);
    if (n_send == 4*num) begin
      i_valid = 1'b1; i_data = 8'hEE;
      check(o_ready == 1'b0, "ready_after_last", o_ready, 0);
      check({o_running, o_done} == 2'b10, "drain_state", {o_running, o_done}, 2'b10);
      tick();
      check({o_running, o_done} == 2'b01, "done_pulse", {o_running, o_done}, 2'b01);
      tick();
      check({o_idle, o_done} == 2'b10, "idle_after_done", {o_idle, o_done}, 2'b10);
      i_valid = 1'b0;
    end else begin
      i_valid = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({o_idle, o_ready, o_ce, o_we, o_done, o_running} == 6'b100000, name,
          {o_idle, o_ready, o_ce, o_we, o_done, o_running}, 6'b100000);
    check(o_addr == '0 && o_wdata == '0, "reset_addr_wdata", {o_addr, o_wdata}, 0);
  endtask

  initial begin
    rst = 1'b1; i_run = 1'b0; i_base_addr = '0; i_num_words = '0;
    i_valid = 1'b0; i_data = '0;

    // Reset held 5 cycles with a run pulse in the middle.
    for (int c = 0; c < 5; c++) begin
      i_run = (c == 2); i_num_words = 7'd3;
      tick();
      check_reset_outputs("reset_outputs");
    end
    i_run = 1'b0;
    rst = 1'b0;

    // Streaming, back-to-back; starts in the first IDLE cycle after reset.
    fill_seq(8'h01, 8);
    xfer(0, 2, 8, 1'b0, 1'b0);
    tick();

    // Same stimulus with random bubbles.
    fill_seq(8'h01, 8);
    xfer(0, 2, 8, 1'b1, 1'b0);

    // Address wrap.
    fill_seq(8'hA0, 8);
    xfer(63, 2, 8, 1'b0, 1'b0);

    // Zero-length request.
    done_q.push_back(1);
    i_run = 1'b1; i_base_addr = 6'd5; i_num_words = '0;
    tick();
    i_run = 1'b0;
    check({o_done, o_we} == 2'b10, "zero_len_done", {o_done, o_we}, 2'b10);
    tick();
    check(o_idle == 1'b1, "zero_len_idle", o_idle, 1);

    // Abort after 5 bytes of a 4-word transfer, run pulse ignored mid-transfer.
    fill_random(16);
    xfer(20, 4, 5, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("abort_reset_outputs");
    rst = 1'b0;
    fill_random(4);
    xfer(45, 1, 4, 1'b1, 1'b0);

    // Randomized transfers, including a full 64-word run.
    for (int t = 0; t < 6; t++) begin
      int b;
      int n;
      b = $urandom_range(0, 63);
      n = $urandom_range(1, 6);
      fill_random(4*n);
      xfer(b, n, 4*n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end
    fill_random(256);
    xfer($urandom_range(0, 63), 64, 256, 1'b1, 1'b0);

    repeat (4) tick();
    check(exp_q.size() == 0, "writes_outstanding", 64'(exp_q.size()), 0);
    check(done_q.size() == 0, "done_outstanding", 64'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
